load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned WORD_BYTES = 4;

    // Access size encoding as carried on req_size
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } lsu_size_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        WAIT,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit: byte-enable masks, store data
// shifting across two words, and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_t   size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        split,
    output logic [31:0] word0,
    output logic [31:0] word1,
    output logic [31:0] load_data
);

    logic [3:0]  base;
    logic [7:0]  mask8;
    logic [63:0] wide;
    logic [31:0] shifted;

    // Masks, store lane shift and load extraction
    always_comb begin
        unique case (size)
            SZ_B:    base = 4'h1;
            SZ_H:    base = 4'h3;
            SZ_W:    base = 4'hF;
            default: base = 4'h0;
        endcase
        mask8 = {4'h0, base} << off;
        be0   = mask8[3:0];
        be1   = mask8[7:4];
        split = |be1;

        wide  = {32'h0, wdata} << {off, 3'b000};
        word0 = wide[31:0];
        word1 = wide[63:32];

        // For non-split loads the wanted bytes all sit in rdata_lo
        shifted = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
        unique case (size)
            SZ_B:    load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            SZ_W:    load_data = shifted;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time to a registered-read, byte-enabled
// word RAM. Misaligned halfword/word accesses become two word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ALLOW_MISALIGNED = 1,
    parameter int unsigned ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;

    logic              we_q;
    lsu_size_t         size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic              split_q;
    logic [3:0]        be1_q;
    logic [31:0]       word1_q;
    logic [31:0]       lo_q;

    logic [3:0]        mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              idle;
    lsu_size_t         al_size;
    logic [1:0]        al_off;
    logic              al_uns;
    logic [31:0]       al_lo;
    logic [3:0]        al_be0, al_be1;
    logic              al_split;
    logic [31:0]       al_word0, al_word1, al_load;
    logic              acc_err;

    // Aligner sees the live request while idle, the latched one afterwards
    always_comb begin
        idle    = (state_q == IDLE);
        al_size = idle ? lsu_size_t'(req_size) : size_q;
        al_off  = idle ? req_addr[1:0] : off_q;
        al_uns  = idle ? req_unsigned : uns_q;
        al_lo   = split_q ? lo_q : mem_rdata;
        acc_err = (req_size == 2'd3) || (al_split && (ALLOW_MISALIGNED == 0));
    end

    lsu_align u_align (
        .size        (al_size),
        .off         (al_off),
        .is_unsigned (al_uns),
        .wdata       (req_wdata),
        .rdata_lo    (al_lo),
        .rdata_hi    (mem_rdata),
        .be0         (al_be0),
        .be1         (al_be1),
        .split       (al_split),
        .word0       (al_word0),
        .word1       (al_word1),
        .load_data   (al_load)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = acc_err ? RESP : ISSUE0;
            ISSUE0:  state_d = split_q ? ISSUE1 : WAIT;
            ISSUE1:  state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = resp_err_q;
        resp_rdata = resp_rdata_q;
        mem_we     = mem_we_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
    end

    // Request latch, memory-side registers and response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            split_q      <= 1'b0;
            be1_q        <= 4'h0;
            word1_q      <= 32'h0;
            lo_q         <= 32'h0;
            mem_we_q     <= 4'h0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= lsu_size_t'(req_size);
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        split_q <= al_split;
                        be1_q   <= al_be1;
                        word1_q <= al_word1;
                        if (acc_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_we_q    <= req_we ? al_be0 : 4'h0;
                            mem_wdata_q <= al_word0;
                        end
                    end
                end
                ISSUE0: begin
                    if (split_q) begin
                        mem_addr_q  <= mem_addr_q + ADDR_W'(WORD_BYTES);
                        mem_we_q    <= we_q ? be1_q : 4'h0;
                        mem_wdata_q <= word1_q;
                    end else begin
                        mem_we_q <= 4'h0;
                    end
                end
                ISSUE1: begin
                    lo_q     <= mem_rdata;
                    mem_we_q <= 4'h0;
                end
                WAIT: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= we_q ? 32'h0 : al_load;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read byte-enabled RAM.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        nm_req_valid = 1'b0, nm_req_ready, nm_resp_valid, nm_resp_err;
    logic [31:0] nm_resp_rdata, nm_mem_addr, nm_mem_wdata;
    logic [3:0]  nm_mem_we;
    logic [31:0] nm_mem_rdata = 32'h0;

    int tests = 0;
    int fails = 0;

    logic [31:0] ram [0:255];

    load_store_unit #(.ALLOW_MISALIGNED(1), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.ALLOW_MISALIGNED(0), .ADDR_W(32)) dut_nm (
        .clk(clk), .rst_n(rst_n),
        .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_we(1'b0),
        .req_size(2'd2), .req_unsigned(1'b0), .req_addr(32'h0000_0102),
        .req_wdata(32'h0), .resp_valid(nm_resp_valid), .resp_err(nm_resp_err),
        .resp_rdata(nm_resp_rdata), .mem_we(nm_mem_we), .mem_addr(nm_mem_addr),
        .mem_wdata(nm_mem_wdata), .mem_rdata(nm_mem_rdata)
    );

    // Registered-read RAM with byte strobes
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        mem_rdata <= ram[mem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single accept edge; returns in cycle T+1
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_err", {31'h0, resp_err}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_we", {28'h0, mem_we}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        #10 rst_n = 1'b1;
        step();

        // sw 0xDEADBEEF -> 0x100
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        check("sw_addr", mem_addr, 32'h100);
        check("sw_we", {28'h0, mem_we}, 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_t1_valid", {31'h0, resp_valid}, 32'h0);
        step();
        check("sw_t2_we", {28'h0, mem_we}, 32'h0);
        check("sw_t2_valid", {31'h0, resp_valid}, 32'h0);
        step();
        check("sw_t3_valid", {31'h0, resp_valid}, 32'h1);
        check("sw_t3_err", {31'h0, resp_err}, 32'h0);
        check("sw_t3_rdata", resp_rdata, 32'h0);
        check("sw_t3_ready", {31'h0, req_ready}, 32'h0);
        step();
        check("sw_t4_valid", {31'h0, resp_valid}, 32'h0);
        check("sw_t4_ready", {31'h0, req_ready}, 32'h1);

        // sb 0xA5 -> 0x103
        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5);
        check("sb_we", {28'h0, mem_we}, 32'h8);
        check("sb_lane", {24'h0, mem_wdata[31:24]}, 32'hA5);
        step(); step(); step();
        check("sb_ram", ram[8'h40], 32'hA5ADBEEF);

        // mem[0x100] = 0x80FF1234
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF1234);
        step(); step(); step();

        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        check("lh_we", {28'h0, mem_we}, 32'h0);
        check("lh_addr", mem_addr, 32'h100);
        step(); step();
        check("lh_valid", {31'h0, resp_valid}, 32'h1);
        check("lh_rdata", resp_rdata, 32'hFFFF80FF);
        step();

        issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
        step(); step();
        check("lhu_rdata", resp_rdata, 32'h000080FF);
        step();

        issue(1'b0, 2'd0, 1'b0, 32'h101, 32'h0);
        step(); step();
        check("lb_rdata", resp_rdata, 32'h00000012);
        step();

        // mem[0xFC] = 0x44332211, mem[0x100] = 0x88776655
        issue(1'b1, 2'd2, 1'b0, 32'hFC, 32'h44332211);
        step(); step(); step();
        issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h88776655);
        step(); step(); step();

        // Split lw 0x0FE
        issue(1'b0, 2'd2, 1'b0, 32'hFE, 32'h0);
        check("lw_split_a0", mem_addr, 32'hFC);
        step();
        check("lw_split_a1", mem_addr, 32'h100);
        check("lw_split_we1", {28'h0, mem_we}, 32'h0);
        step();
        check("lw_split_t3_valid", {31'h0, resp_valid}, 32'h0);
        step();
        check("lw_split_t4_valid", {31'h0, resp_valid}, 32'h1);
        check("lw_split_rdata", resp_rdata, 32'h66554433);
        step();

        // Split sw 0x11223344 -> 0x1FF
        issue(1'b1, 2'd2, 1'b0, 32'h1FF, 32'h11223344);
        check("sw_split_a0", mem_addr, 32'h1FC);
        check("sw_split_we0", {28'h0, mem_we}, 32'h8);
        check("sw_split_d0", {24'h0, mem_wdata[31:24]}, 32'h44);
        step();
        check("sw_split_a1", mem_addr, 32'h200);
        check("sw_split_we1", {28'h0, mem_we}, 32'h7);
        check("sw_split_d1", {8'h0, mem_wdata[23:0]}, 32'h112233);
        step();
        check("sw_split_t3_valid", {31'h0, resp_valid}, 32'h0);
        step();
        check("sw_split_t4_valid", {31'h0, resp_valid}, 32'h1);
        check("sw_split_rdata", resp_rdata, 32'h0);
        check("sw_split_ram0", {24'h0, ram[8'h7F][31:24]}, 32'h44);
        check("sw_split_ram1", {8'h0, ram[8'h80][23:0]}, 32'h112233);
        step();

        // Illegal size
        issue(1'b1, 2'd3, 1'b0, 32'h104, 32'h12345678);
        check("ill_valid", {31'h0, resp_valid}, 32'h1);
        check("ill_err", {31'h0, resp_err}, 32'h1);
        check("ill_rdata", resp_rdata, 32'h0);
        check("ill_we", {28'h0, mem_we}, 32'h0);
        step();
        check("ill_hold_err", {31'h0, resp_err}, 32'h1);
        check("ill_after_valid", {31'h0, resp_valid}, 32'h0);
        check("ill_after_ready", {31'h0, req_ready}, 32'h1);

        // Misaligned lw 0x102 on the strict instance
        nm_req_valid = 1'b1;
        step();
        nm_req_valid = 1'b0;
        check("nm_valid", {31'h0, nm_resp_valid}, 32'h1);
        check("nm_err", {31'h0, nm_resp_err}, 32'h1);
        check("nm_we", {28'h0, nm_mem_we}, 32'h0);
        check("nm_addr", nm_mem_addr, 32'h0);
        step();
        check("nm_after_valid", {31'h0, nm_resp_valid}, 32'h0);

        // Reset during ISSUE1 of a split store
        issue(1'b1, 2'd2, 1'b0, 32'h1FF, 32'hAABBCCDD);
        step();
        check("rmid_we_before", {28'h0, mem_we}, 32'h7);
        rst_n = 1'b0;
        #1;
        check("rmid_we", {28'h0, mem_we}, 32'h0);
        check("rmid_valid", {31'h0, resp_valid}, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rmid_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        check("rmid_ready", {31'h0, req_ready}, 32'h1);
        check("rmid_ram0", {24'h0, ram[8'h7F][31:24]}, 32'hDD);
        check("rmid_ram1", {8'h0, ram[8'h80][23:0]}, 32'h112233);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
